// File: rtl/retire_sequencer.sv
// ============================================================================
// Module   : retire_sequencer
// Purpose  : Buffers multi-slot commit bundles and replays the set slots one
//            instruction per handshake toward the trace encoder.
//            Optional macro RETIRE_SEQ_DROP_CNT_EN adds a saturating drop count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module retire_sequencer #(
    parameter int NR_RETIRED = 2,
    parameter int DEPTH      = 4,
    parameter int XLEN       = 64,
    parameter int ITYPE_LEN  = 3,
    parameter int CAUSE_LEN  = 5,
    parameter int TVAL_LEN   = 64,
    parameter int PRIV_LEN   = 2
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NR_RETIRED-1:0]           iretire_i,
    input  logic [NR_RETIRED-1:0]           ilastsize_i,
    input  logic [NR_RETIRED*ITYPE_LEN-1:0] itype_i,
    input  logic [CAUSE_LEN-1:0]            cause_i,
    input  logic [TVAL_LEN-1:0]             tval_i,
    input  logic [PRIV_LEN-1:0]             priv_i,
    input  logic [NR_RETIRED*XLEN-1:0]      iaddr_i,
    input  logic                            ready_i,
    output logic                            valid_o,
    output logic                            ilastsize_o,
    output logic [ITYPE_LEN-1:0]            itype_o,
    output logic [CAUSE_LEN-1:0]            cause_o,
    output logic [TVAL_LEN-1:0]             tval_o,
    output logic [PRIV_LEN-1:0]             priv_o,
    output logic [XLEN-1:0]                 iaddr_o,
    output logic                            full_o,
`ifdef RETIRE_SEQ_DROP_CNT_EN
    output logic [15:0]                     drop_cnt_o,
`endif
    output logic                            overflow_o
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int SLOT_W = (NR_RETIRED > 1) ? $clog2(NR_RETIRED) : 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    state_e                                state_q, state_d;
    logic [NR_RETIRED-1:0]                 mask_q  [DEPTH];
    logic [NR_RETIRED-1:0]                 mask_d  [DEPTH];
    logic [NR_RETIRED-1:0]                 lsz_q   [DEPTH];
    logic [NR_RETIRED-1:0]                 lsz_d   [DEPTH];
    logic [NR_RETIRED-1:0][ITYPE_LEN-1:0]  itype_q [DEPTH];
    logic [NR_RETIRED-1:0][ITYPE_LEN-1:0]  itype_d [DEPTH];
    logic [NR_RETIRED-1:0][XLEN-1:0]       iaddr_q [DEPTH];
    logic [NR_RETIRED-1:0][XLEN-1:0]       iaddr_d [DEPTH];
    logic [CAUSE_LEN-1:0]                  cause_q [DEPTH];
    logic [CAUSE_LEN-1:0]                  cause_d [DEPTH];
    logic [TVAL_LEN-1:0]                   tval_q  [DEPTH];
    logic [TVAL_LEN-1:0]                   tval_d  [DEPTH];
    logic [PRIV_LEN-1:0]                   priv_q  [DEPTH];
    logic [PRIV_LEN-1:0]                   priv_d  [DEPTH];
    logic [PTR_W-1:0]                      rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CNT_W-1:0]                      count_q, count_d;
    logic [SLOT_W-1:0]                     slot_q, slot_d;
    logic                                  overflow_q, overflow_d;
`ifdef RETIRE_SEQ_DROP_CNT_EN
    logic [15:0]                           drop_cnt_q, drop_cnt_d;
`endif

    logic                                  w_empty, w_full, w_push, w_drop;
    logic                                  w_xfer, w_last, w_pop;
    logic [NR_RETIRED-1:0]                 w_head_mask;
    logic [SLOT_W:0]                       w_next;
    logic [PTR_W-1:0]                      w_rptr_inc;

    function automatic logic [SLOT_W-1:0] lowest_set(input logic [NR_RETIRED-1:0] m);
        lowest_set = '0;
        for (int i = NR_RETIRED - 1; i >= 0; i--) begin
            if (m[i]) lowest_set = SLOT_W'(i);
        end
    endfunction

    // MSB flags that a set bit exists strictly above cur; low bits give its index.
    function automatic logic [SLOT_W:0] next_above(input logic [NR_RETIRED-1:0] m,
                                                   input logic [SLOT_W-1:0]     cur);
        next_above = '0;
        for (int i = NR_RETIRED - 1; i >= 0; i--) begin
            if (m[i] && (SLOT_W'(i) > cur)) next_above = {1'b1, SLOT_W'(i)};
        end
    endfunction

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        lsz_d      = lsz_q;
        itype_d    = itype_q;
        iaddr_d    = iaddr_q;
        cause_d    = cause_q;
        tval_d     = tval_q;
        priv_d     = priv_q;
        rptr_d     = rptr_q;
        wptr_d     = wptr_q;
        count_d    = count_q;
        slot_d     = slot_q;

        w_empty     = (count_q == '0);
        w_full      = (count_q == CNT_W'(DEPTH));
        w_push      = (|iretire_i) && !w_full;
        w_drop      = (|iretire_i) && w_full;
        w_head_mask = mask_q[rptr_q];
        w_next      = next_above(w_head_mask, slot_q);
        w_xfer      = !w_empty && ready_i;
        w_last      = !w_next[SLOT_W];
        w_pop       = w_xfer && w_last;
        w_rptr_inc  = rptr_q + 1'b1;

        overflow_d  = w_drop;
`ifdef RETIRE_SEQ_DROP_CNT_EN
        drop_cnt_d  = (w_drop && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1 : drop_cnt_q;
`endif

        if (w_push) begin
            mask_d[wptr_q]  = iretire_i;
            lsz_d[wptr_q]   = ilastsize_i;
            itype_d[wptr_q] = itype_i;
            iaddr_d[wptr_q] = iaddr_i;
            cause_d[wptr_q] = cause_i;
            tval_d[wptr_q]  = tval_i;
            priv_d[wptr_q]  = priv_i;
            wptr_d          = wptr_q + 1'b1;
        end
        if (w_pop) rptr_d = w_rptr_inc;

        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE: begin
                if (w_push) begin
                    state_d = DRAIN;
                    slot_d  = lowest_set(iretire_i);
                end
            end
            DRAIN: begin
                if (w_xfer) begin
                    if (!w_last) begin
                        slot_d = w_next[SLOT_W-1:0];
                    end else if (count_q > CNT_W'(1)) begin
                        slot_d = lowest_set(mask_q[w_rptr_inc]);
                    // Sole bundle leaving while a new one lands: it becomes the head.
                    end else if (w_push) begin
                        slot_d = lowest_set(iretire_i);
                    end else begin
                        slot_d  = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            rptr_q     <= '0;
            wptr_q     <= '0;
            count_q    <= '0;
            slot_q     <= '0;
            overflow_q <= 1'b0;
`ifdef RETIRE_SEQ_DROP_CNT_EN
            drop_cnt_q <= '0;
`endif
            for (int i = 0; i < DEPTH; i++) begin
                mask_q[i]  <= '0;
                lsz_q[i]   <= '0;
                itype_q[i] <= '0;
                iaddr_q[i] <= '0;
                cause_q[i] <= '0;
                tval_q[i]  <= '0;
                priv_q[i]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            rptr_q     <= rptr_d;
            wptr_q     <= wptr_d;
            count_q    <= count_d;
            slot_q     <= slot_d;
            overflow_q <= overflow_d;
`ifdef RETIRE_SEQ_DROP_CNT_EN
            drop_cnt_q <= drop_cnt_d;
`endif
            mask_q     <= mask_d;
            lsz_q      <= lsz_d;
            itype_q    <= itype_d;
            iaddr_q    <= iaddr_d;
            cause_q    <= cause_d;
            tval_q     <= tval_d;
            priv_q     <= priv_d;
        end
    end

    // Instruction outputs are forced to zero whenever nothing is queued.
    always_comb begin
        valid_o     = !w_empty;
        ilastsize_o = valid_o ? lsz_q[rptr_q][slot_q]   : 1'b0;
        itype_o     = valid_o ? itype_q[rptr_q][slot_q] : '0;
        iaddr_o     = valid_o ? iaddr_q[rptr_q][slot_q] : '0;
        cause_o     = valid_o ? cause_q[rptr_q]         : '0;
        tval_o      = valid_o ? tval_q[rptr_q]          : '0;
        priv_o      = valid_o ? priv_q[rptr_q]          : '0;
        full_o      = w_full;
        overflow_o  = overflow_q;
`ifdef RETIRE_SEQ_DROP_CNT_EN
        drop_cnt_o  = drop_cnt_q;
`endif
    end

endmodule

`default_nettype wire

// File: tb/tb_retire_sequencer.sv
// ============================================================================
// Module   : tb_retire_sequencer
// Purpose  : Scoreboard bench for retire_sequencer (NR_RETIRED=2, DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_retire_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [1:0]  iretire = '0;
    logic [1:0]  ilastsize = '0;
    logic [5:0]  itype = '0;
    logic [4:0]  cause = '0;
    logic [63:0] tval = '0;
    logic [1:0]  priv = '0;
    logic [127:0] iaddr = '0;
    logic        ready = 1'b0;

    logic        valid_o, ilastsize_o, full_o, overflow_o;
    logic [2:0]  itype_o;
    logic [4:0]  cause_o;
    logic [63:0] tval_o, iaddr_o;
    logic [1:0]  priv_o;
`ifdef RETIRE_SEQ_DROP_CNT_EN
    logic [15:0] drop_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    retire_sequencer #(
        .NR_RETIRED(2), .DEPTH(4), .XLEN(64), .ITYPE_LEN(3),
        .CAUSE_LEN(5), .TVAL_LEN(64), .PRIV_LEN(2)
    ) u_dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .iretire_i   (iretire),
        .ilastsize_i (ilastsize),
        .itype_i     (itype),
        .cause_i     (cause),
        .tval_i      (tval),
        .priv_i      (priv),
        .iaddr_i     (iaddr),
        .ready_i     (ready),
        .valid_o     (valid_o),
        .ilastsize_o (ilastsize_o),
        .itype_o     (itype_o),
        .cause_o     (cause_o),
        .tval_o      (tval_o),
        .priv_o      (priv_o),
        .iaddr_o     (iaddr_o),
        .full_o      (full_o),
`ifdef RETIRE_SEQ_DROP_CNT_EN
        .drop_cnt_o  (drop_cnt_o),
`endif
        .overflow_o  (overflow_o)
    );

    typedef struct packed {
        logic [63:0] addr;
        logic [2:0]  itype;
        logic        lsz;
        logic [4:0]  cause;
        logic [63:0] tval;
        logic [1:0]  priv;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_out    = 0;
    int          nb;
    logic        mon_en   = 1'b0;
    logic        ovf_exp  = 1'b0;
    logic [15:0] drops_exp = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change just after the rising edge and are held for one cycle.
    task automatic drive(input logic [1:0] m, input logic [63:0] a0, input logic [63:0] a1,
                         input logic rdy);
        iretire   = m;
        iaddr     = {a1, a0};
        itype     = 6'($urandom);
        ilastsize = 2'($urandom);
        cause     = 5'($urandom);
        tval      = {$urandom, $urandom};
        priv      = 2'($urandom);
        ready     = rdy;
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) drive(2'b00, 64'h0, 64'h0, 1'b1);
        drive(2'b00, 64'h0, 64'h0, 1'b1);
        chk("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    always @(negedge clk_i) begin
        if (mon_en && !rst_i) begin
            nb = 0;
            foreach (sb[k]) if (sb[k].last) nb++;
            chk("overflow", 64'(overflow_o), 64'(ovf_exp));
`ifdef RETIRE_SEQ_DROP_CNT_EN
            chk("drop_cnt", 64'(drop_cnt_o), 64'(drops_exp));
`endif
            chk("valid", 64'(valid_o), 64'(sb.size() != 0));
            chk("full", 64'(full_o), 64'(nb == 4));
            if (valid_o && sb.size() != 0) begin
                e = sb[0];
                chk("iaddr", iaddr_o, e.addr);
                chk("itype", 64'(itype_o), 64'(e.itype));
                chk("lastsize", 64'(ilastsize_o), 64'(e.lsz));
                chk("cause", 64'(cause_o), 64'(e.cause));
                chk("tval", tval_o, e.tval);
                chk("priv", 64'(priv_o), 64'(e.priv));
                if (ready) begin
                    void'(sb.pop_front());
                    n_out++;
                end
            end
            ovf_exp = (iretire != 2'b00) && (nb >= 4);
            if (ovf_exp && drops_exp != 16'hFFFF) drops_exp++;
            if (iretire != 2'b00 && nb < 4) begin
                for (int s = 0; s < 2; s++) begin
                    if (iretire[s]) begin
                        e.addr  = iaddr[s*64 +: 64];
                        e.itype = itype[s*3 +: 3];
                        e.lsz   = ilastsize[s];
                        e.cause = cause;
                        e.tval  = tval;
                        e.priv  = priv;
                        e.last  = (s == 1) || !iretire[1];
                        sb.push_back(e);
                    end
                end
            end
        end
    end

    task automatic check_zero_outputs(input string tag);
        chk(tag, 64'({valid_o, full_o, overflow_o, ilastsize_o, itype_o, cause_o, priv_o}), 64'd0);
        chk({tag, "_iaddr"}, iaddr_o, 64'd0);
        chk({tag, "_tval"}, tval_o, 64'd0);
    endtask

    int base;

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        check_zero_outputs("reset_outputs");
        rst_i  = 1'b0;
        mon_en = 1'b1;

        // Dual-slot bundle, then drain.
        drive(2'b11, 64'h80, 64'h84, 1'b1);
        repeat (3) drive(2'b00, 64'h0, 64'h0, 1'b1);

        // Sparse mask: only slot 1 may appear.
        base = n_out;
        drive(2'b10, 64'h111, 64'h200, 1'b1);
        repeat (2) drive(2'b00, 64'h0, 64'h0, 1'b1);
        chk("sparse_count", 64'(n_out - base), 64'd1);

        // Backpressure for three cycles, then release.
        drive(2'b11, 64'h80, 64'h84, 1'b0);
        repeat (3) drive(2'b00, 64'h0, 64'h0, 1'b0);
        wait_drain();

        // Overflow: five bundles with the encoder stalled.
        base = n_out;
        for (int i = 0; i < 5; i++) drive(2'b11, 64'h1000 + 64'(i * 16), 64'h1004 + 64'(i * 16), 1'b0);
        drive(2'b00, 64'h0, 64'h0, 1'b0);
        wait_drain();
        chk("overflow_drain_count", 64'(n_out - base), 64'd8);

        // Push while full, coinciding with the pop of the head's final slot.
        for (int i = 0; i < 4; i++) drive(2'b11, 64'h2000 + 64'(i * 16), 64'h2004 + 64'(i * 16), 1'b0);
        drive(2'b00, 64'h0, 64'h0, 1'b1);
        drive(2'b11, 64'h9000, 64'h9004, 1'b1);
        drive(2'b00, 64'h0, 64'h0, 1'b0);
        chk("full_after_drop_pop", 64'(full_o), 64'd0);
        wait_drain();

        // Asynchronous reset while two bundles are queued and one is mid-drain.
        drive(2'b11, 64'h3000, 64'h3004, 1'b0);
        drive(2'b11, 64'h3010, 64'h3014, 1'b0);
        drive(2'b00, 64'h0, 64'h0, 1'b1);
        mon_en = 1'b0;
        #2;
        rst_i = 1'b1;
        #1;
        check_zero_outputs("async_reset");
        sb.delete();
        ovf_exp   = 1'b0;
        drops_exp = '0;
        @(posedge clk_i);
        #1;
        rst_i  = 1'b0;
        mon_en = 1'b1;
        base   = n_out;
        repeat (4) drive(2'b00, 64'h0, 64'h0, 1'b1);
        chk("no_stale_after_reset", 64'(n_out - base), 64'd0);

        // Random traffic with random backpressure.
        for (int i = 0; i < 300; i++) begin
            drive(2'($urandom), {32'h0, $urandom}, {32'h0, $urandom}, ($urandom_range(0, 3) != 0));
        end
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/retire_sequencer.md
Name: retire_sequencer

Overview:
Front-end scheduler between the CVA6 commit port and the single-lane trace encoder path.
- Captures one multi-retirement bundle per cycle (up to NrRetiredInstr slots) into a bundle FIFO.
- Serialises the set slots, in ascending slot order, into one instruction per handshake toward the encoder.
- Absorbs encoder backpressure; drops and flags bundles on overflow, since the core cannot be stalled.

Parameters:
- NR_RETIRED, 2, commit slots per bundle (mure_pkg::NrRetiredInstr)
- DEPTH, 4, bundle FIFO entries; power of two, >=2
- XLEN, 64, instruction address width
- ITYPE_LEN, 3, itype width
- CAUSE_LEN, 5, cause width
- TVAL_LEN, 64, tval width
- PRIV_LEN, 2, privilege width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- iretire_i  in  NR_RETIRED  per-slot retire valid
- ilastsize_i  in  NR_RETIRED  per-slot last-size bit
- itype_i  in  NR_RETIRED x ITYPE_LEN  per-slot itype
- cause_i  in  CAUSE_LEN  bundle cause
- tval_i  in  TVAL_LEN  bundle tval
- priv_i  in  PRIV_LEN  bundle privilege
- iaddr_i  in  NR_RETIRED x XLEN  per-slot address
- ready_i  in  1  encoder accepts current instruction
- valid_o  out  1  instruction outputs valid
- ilastsize_o  out  1  selected slot last-size
- itype_o  out  ITYPE_LEN  selected slot itype
- cause_o  out  CAUSE_LEN  head bundle cause
- tval_o  out  TVAL_LEN  head bundle tval
- priv_o  out  PRIV_LEN  head bundle priv
- iaddr_o  out  XLEN  selected slot address
- full_o  out  1  FIFO holds DEPTH bundles
- overflow_o  out  1  one-cycle pulse: a bundle was dropped

Behaviour:
- Reset (async, rst_i=1): FIFO empty, slot pointer 0, state IDLE. All outputs 0, including valid_o, full_o and overflow_o.
- Push:
  - Occurs when |iretire_i and !full.
  - Stores the full bundle: mask, per-slot fields and bundle fields.
  - Bundles with iretire_i==0 are ignored and never stored.
- Full:
  - Derived from the registered count, so it is stable for the whole cycle.
  - Push while full drops the bundle, even if a pop occurs in the same cycle.
  - overflow_o rises the cycle after the drop, for exactly 1 cycle per dropped bundle.
- Latency: a bundle presented in cycle N, with the FIFO empty, gives valid_o=1 in cycle N+1. There is no combinational input-to-output path.
- Output selection:
  - valid_o = !empty.
  - Outputs come from the FIFO head, at the slot given by the registered slot pointer.
  - The pointer always addresses a set mask bit.
  - cause/tval/priv are replicated on every instruction of the bundle.
- Handshake:
  - Transfer happens when valid_o & ready_i.
  - With valid_o=1 and ready_i=0, all outputs hold stable.
  - ready_i is ignored while valid_o=0.
- FSM:
  - IDLE: FIFO empty. On push, go to DRAIN; the pointer loads the lowest set bit of the mask.
  - DRAIN, on transfer, if a higher set bit remains in the head mask: the pointer moves to the next set bit. Non-contiguous masks skip the zero slots.
  - DRAIN, on transfer at the last set bit: pop the head and load the pointer with the lowest set bit of the next head. Go to IDLE if the FIFO becomes empty, else stay in DRAIN.
- Simultaneous push and pop (not full): both occur and the count is unchanged.
- Pointer arithmetic: DEPTH-based, wraps modulo DEPTH. The count register is clog2(DEPTH)+1 bits.
- Throughput: 1 instruction per cycle while ready_i=1. No bubble between bundles.

Optional Feature:
- Macro: RETIRE_SEQ_DROP_CNT_EN.
- With the macro defined:
  - Adds output port drop_cnt_o [15:0].
  - 16-bit counter increments on every dropped bundle and saturates at 16'hFFFF.
  - Reset value 0.
- Without the macro: the port and the counter are absent. overflow_o remains the only drop indication.

Test Plan (NR_RETIRED=2, DEPTH=4):
- Reset: assert rst_i mid-drain with 2 bundles queued -> outputs 0 immediately; valid_o=0 after release; no stale instruction emitted.
- Dual-slot bundle: mask=2'b11, iaddr={0x84,0x80}, ready_i=1 -> cycle N+1 iaddr_o=0x80; cycle N+2 iaddr_o=0x84; cycle N+3 valid_o=0.
- Sparse mask: mask=2'b10, iaddr[1]=0x200 -> single instruction iaddr_o=0x200. Slot 0 is never emitted.
- Backpressure: mask=2'b11 with ready_i=0 for 3 cycles -> iaddr_o holds 0x80, cause/tval/priv stable. Release gives 0x80 then 0x84.
- Overflow: ready_i=0, push 5 bundles on consecutive cycles -> full_o=1 after the 4th. The 5th is dropped; overflow_o=1 for one cycle; drop_cnt_o=1 when the macro is enabled. Draining yields 8 instructions in order.
- Push while full with a simultaneous pop (ready_i=1 at the final slot of the head) -> incoming bundle is still dropped, overflow_o pulses, count becomes 3.
